// File: rtl/dma_copy_device.sv
// Memory-to-memory word copy engine: register port for configuration/status
// plus a bus initiator that alternates single-word reads and writes.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for START
// RD      | read request at working src, waiting for m_ack_i
// WR      | write request of latched word at working dst
// GAP     | one cycle with m_sel_o low between words; abort/finish check
// DONE_ST | one-cycle completion: set DONE, raise irq if enabled
module dma_copy_device #(
    parameter int LEN_WIDTH = 16
) (
    input  logic        clk,
    input  logic        reset_i,
    input  logic        sel_i,
    input  logic        wr_en_i,
    input  logic [11:0] address_in_i,
    input  logic [31:0] data_in_i,
    output logic [31:0] data_out_o,
    output logic        ack_o,
    output logic        m_sel_o,
    output logic [31:0] m_addr_o,
    output logic        m_we_o,
    output logic [31:0] m_data_out_o,
    output logic [3:0]  m_wr_mask_o,
    input  logic [31:0] m_data_in_i,
    input  logic        m_ack_i,
    input  logic        dma_eoi_i,
    output logic        dma_irq_o
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD      = 3'd1,
        WR      = 3'd2,
        GAP     = 3'd3,
        DONE_ST = 3'd4
    } state_t;

    localparam logic [2:0] REG_SRC    = 3'd0;
    localparam logic [2:0] REG_DST    = 3'd1;
    localparam logic [2:0] REG_LEN    = 3'd2;
    localparam logic [2:0] REG_CTRL   = 3'd3;
    localparam logic [2:0] REG_REMAIN = 3'd4;

    state_t               state;
    logic                 hold;
    logic [31:0]          src_r;
    logic [31:0]          dst_r;
    logic [LEN_WIDTH-1:0] len_r;
    logic                 irq_en;
    logic [31:0]          src_w;
    logic [31:0]          dst_w;
    logic [LEN_WIDTH-1:0] remain;
    logic                 done;
    logic                 aborted;
    logic                 abort_pend;

    logic        access;
    logic        wr_strobe;
    logic        rd_strobe;
    logic [2:0]  reg_idx;
    logic        busy;
    logic        ctrl_wr;
    logic        start_req;
    logic        abort_req;
    logic        cfg_wr;
    logic [31:0] rd_val;
    logic        unused_addr_bits;

    assign reg_idx   = address_in_i[4:2];
    // hold blocks a second ack until sel_i has been seen low
    assign access    = sel_i && !hold;
    assign wr_strobe = access && wr_en_i;
    assign rd_strobe = access && !wr_en_i;
    assign busy      = (state == RD) || (state == WR) || (state == GAP);
    assign ctrl_wr   = wr_strobe && (reg_idx == REG_CTRL);
    assign start_req = ctrl_wr && data_in_i[0] && (state == IDLE);
    assign abort_req = ctrl_wr && data_in_i[2] && busy;
    assign cfg_wr    = wr_strobe && (state == IDLE);

    assign m_wr_mask_o      = 4'hF;
    assign unused_addr_bits = ^{address_in_i[11:5], address_in_i[1:0]};

    always_comb begin
        rd_val = '0;
        case (reg_idx)
            REG_SRC:    rd_val = src_r;
            REG_DST:    rd_val = dst_r;
            REG_LEN:    rd_val = 32'(len_r);
            REG_CTRL:   rd_val = {28'd0, aborted, irq_en, done, busy};
            REG_REMAIN: rd_val = 32'(remain);
            default:    rd_val = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            hold       <= 1'b0;
            ack_o      <= 1'b0;
            data_out_o <= '0;
            src_r      <= '0;
            dst_r      <= '0;
            len_r      <= '0;
            irq_en     <= 1'b0;
        end else begin
            hold       <= sel_i;
            ack_o      <= access;
            data_out_o <= rd_strobe ? rd_val : '0;
            if (cfg_wr) begin
                case (reg_idx)
                    REG_SRC: src_r <= {data_in_i[31:2], 2'b00};
                    REG_DST: dst_r <= {data_in_i[31:2], 2'b00};
                    REG_LEN: len_r <= data_in_i[LEN_WIDTH-1:0];
                    default: ;
                endcase
            end
            if (ctrl_wr) begin
                irq_en <= data_in_i[1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            state        <= IDLE;
            src_w        <= '0;
            dst_w        <= '0;
            remain       <= '0;
            done         <= 1'b0;
            aborted      <= 1'b0;
            abort_pend   <= 1'b0;
            dma_irq_o    <= 1'b0;
            m_sel_o      <= 1'b0;
            m_we_o       <= 1'b0;
            m_addr_o     <= '0;
            m_data_out_o <= '0;
        end else begin
            if (dma_eoi_i) begin
                dma_irq_o <= 1'b0;
            end
            if (abort_req) begin
                abort_pend <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start_req) begin
                        src_w      <= src_r;
                        dst_w      <= dst_r;
                        remain     <= len_r;
                        done       <= 1'b0;
                        aborted    <= 1'b0;
                        abort_pend <= 1'b0;
                        if (len_r == '0) begin
                            state <= DONE_ST;
                        end else begin
                            state    <= RD;
                            m_sel_o  <= 1'b1;
                            m_we_o   <= 1'b0;
                            m_addr_o <= src_r;
                        end
                    end
                end
                RD: begin
                    if (m_ack_i) begin
                        state        <= WR;
                        m_we_o       <= 1'b1;
                        m_addr_o     <= dst_w;
                        m_data_out_o <= m_data_in_i;
                    end
                end
                WR: begin
                    if (m_ack_i) begin
                        state   <= GAP;
                        src_w   <= src_w + 32'd4;
                        dst_w   <= dst_w + 32'd4;
                        remain  <= remain - LEN_WIDTH'(1);
                        m_sel_o <= 1'b0;
                        m_we_o  <= 1'b0;
                    end
                end
                GAP: begin
                    // an abort landing in this very cycle still stops here
                    if (abort_pend || abort_req) begin
                        aborted <= 1'b1;
                        state   <= DONE_ST;
                    end else if (remain == '0) begin
                        state <= DONE_ST;
                    end else begin
                        state    <= RD;
                        m_sel_o  <= 1'b1;
                        m_we_o   <= 1'b0;
                        m_addr_o <= src_w;
                    end
                end
                DONE_ST: begin
                    done       <= 1'b1;
                    abort_pend <= 1'b0;
                    if (irq_en) begin
                        dma_irq_o <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_copy_device.sv
// Scoreboard bench for dma_copy_device: a 2-cycle-ack memory model, queued
// expected bus transactions and register reads checked by a negedge monitor.
module tb_dma_copy_device;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        sel_i;
    logic        wr_en_i;
    logic [11:0] address_in_i;
    logic [31:0] data_in_i;
    logic [31:0] data_out_o;
    logic        ack_o;
    logic        m_sel_o;
    logic [31:0] m_addr_o;
    logic        m_we_o;
    logic [31:0] m_data_out_o;
    logic [3:0]  m_wr_mask_o;
    logic [31:0] m_data_in_i;
    logic        m_ack_i;
    logic        dma_eoi_i;
    logic        dma_irq_o;

    always #5 clk = ~clk;

    dma_copy_device #(.LEN_WIDTH(16)) dut (
        .clk          (clk),
        .reset_i      (reset_i),
        .sel_i        (sel_i),
        .wr_en_i      (wr_en_i),
        .address_in_i (address_in_i),
        .data_in_i    (data_in_i),
        .data_out_o   (data_out_o),
        .ack_o        (ack_o),
        .m_sel_o      (m_sel_o),
        .m_addr_o     (m_addr_o),
        .m_we_o       (m_we_o),
        .m_data_out_o (m_data_out_o),
        .m_wr_mask_o  (m_wr_mask_o),
        .m_data_in_i  (m_data_in_i),
        .m_ack_i      (m_ack_i),
        .dma_eoi_i    (dma_eoi_i),
        .dma_irq_o    (dma_irq_o)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } bus_t;

    bus_t        bus_exp[$];
    logic [31:0] rd_exp[$];
    int          tests_run    = 0;
    int          tests_failed = 0;
    logic        cur_is_read  = 1'b0;
    logic        seen_sel     = 1'b0;
    logic        prev_sel     = 1'b0;
    int          low_run      = 0;

    function automatic logic [31:0] memval(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic report_fail(input string name, input logic [31:0] act);
        tests_run++;
        tests_failed++;
        $display("FAIL %s: observed 0x%08h, expected no such event", name, act);
    endtask

    // memory model: acks the second cycle of each request, one-cycle pulse
    initial begin
        int cnt;
        cnt         = 0;
        m_ack_i     = 1'b0;
        m_data_in_i = '0;
        forever begin
            @(posedge clk);
            #1;
            if (m_ack_i) begin
                m_ack_i = 1'b0;
                cnt     = 0;
            end else if (m_sel_o) begin
                cnt++;
                if (cnt >= 2) begin
                    m_ack_i = 1'b1;
                    if (!m_we_o) m_data_in_i = memval(m_addr_o);
                end
            end else begin
                cnt = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset_i) begin
            if (ack_o && cur_is_read) begin
                if (rd_exp.size() == 0) begin
                    report_fail("reg_unexpected_read", data_out_o);
                end else begin
                    chk($sformatf("reg_read@%03h", address_in_i), data_out_o, rd_exp.pop_front());
                end
            end
            if (m_sel_o && m_ack_i) begin
                if (bus_exp.size() == 0) begin
                    report_fail("bus_unexpected", m_addr_o);
                end else begin
                    bus_t b;
                    b = bus_exp.pop_front();
                    chk("bus_we", 32'(m_we_o), 32'(b.we));
                    chk("bus_addr", m_addr_o, b.addr);
                    chk("bus_mask", 32'(m_wr_mask_o), 32'hF);
                    if (b.we) chk("bus_wdata", m_data_out_o, b.data);
                end
            end
            if (m_sel_o) begin
                if (seen_sel && !prev_sel) chk("gap_len", low_run, 1);
                seen_sel = 1'b1;
                low_run  = 0;
            end else if (seen_sel) begin
                low_run++;
            end
            prev_sel = m_sel_o;
        end
    end

    task automatic reg_access(input logic we, input logic [11:0] a, input logic [31:0] d);
        int n;
        @(negedge clk);
        cur_is_read  = !we;
        sel_i        = 1'b1;
        wr_en_i      = we;
        address_in_i = a;
        data_in_i    = d;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!ack_o && n < 10);
        if (!ack_o) report_fail("reg_ack_timeout", 32'(a));
        sel_i   = 1'b0;
        wr_en_i = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic reg_write(input logic [11:0] a, input logic [31:0] d);
        reg_access(1'b1, a, d);
    endtask

    task automatic reg_read(input logic [11:0] a, input logic [31:0] exp);
        rd_exp.push_back(exp);
        reg_access(1'b0, a, 32'd0);
    endtask

    task automatic push_copy(input logic [31:0] src, input logic [31:0] dst, input int n);
        for (int i = 0; i < n; i++) begin
            logic [31:0] s;
            logic [31:0] d;
            s = src + 32'(4 * i);
            d = dst + 32'(4 * i);
            bus_exp.push_back('{1'b0, s, 32'd0});
            bus_exp.push_back('{1'b1, d, memval(s)});
        end
    endtask

    task automatic wait_bus_empty();
        int n;
        n = 0;
        while (bus_exp.size() != 0 && n < 1000) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (bus_exp.size() != 0) begin
            report_fail("bus_timeout", 32'(bus_exp.size()));
            bus_exp.delete();
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset_i      = 1'b1;
        sel_i        = 1'b0;
        wr_en_i      = 1'b0;
        address_in_i = '0;
        data_in_i    = '0;
        dma_eoi_i    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_sel", 32'(m_sel_o), 0);
        chk("rst_m_we", 32'(m_we_o), 0);
        chk("rst_m_addr", m_addr_o, 0);
        chk("rst_ack", 32'(ack_o), 0);
        chk("rst_data_out", data_out_o, 0);
        chk("rst_irq", 32'(dma_irq_o), 0);
        @(negedge clk);
        reset_i = 1'b0;
        reg_read(12'h000, 32'h0);
        reg_read(12'h008, 32'h0);
        reg_read(12'h00C, 32'h0);
        reg_read(12'h010, 32'h0);

        // unmapped offset
        reg_write(12'h014, 32'hFFFF_FFFF);
        reg_read(12'h014, 32'h0);
        reg_read(12'h01C, 32'h0);

        // basic 3-word copy, low SRC bits dropped
        seen_sel = 1'b0;
        reg_write(12'h000, 32'h0000_0103);
        reg_write(12'h004, 32'h0000_0200);
        reg_write(12'h008, 32'h0000_0003);
        reg_read(12'h000, 32'h0000_0100);
        push_copy(32'h100, 32'h200, 3);
        reg_write(12'h00C, 32'h1);
        wait_bus_empty();
        reg_read(12'h00C, 32'h2);
        reg_read(12'h010, 32'h0);
        reg_read(12'h008, 32'h3);
        reg_write(12'h00C, 32'h4);
        reg_read(12'h00C, 32'h2);

        // zero length with irq
        seen_sel = 1'b0;
        reg_write(12'h008, 32'h0);
        reg_write(12'h00C, 32'h3);
        n = 0;
        while (!dma_irq_o && n < 2) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("irq_rise", 32'(dma_irq_o), 1);
        repeat (3) @(posedge clk);
        #1;
        chk("irq_hold", 32'(dma_irq_o), 1);
        reg_read(12'h00C, 32'h6);
        reg_write(12'h00C, 32'h0);
        chk("irq_after_irqen_clear", 32'(dma_irq_o), 1);
        reg_read(12'h00C, 32'h2);
        @(negedge clk);
        dma_eoi_i = 1'b1;
        @(posedge clk);
        #1;
        dma_eoi_i = 1'b0;
        chk("irq_eoi_clear", 32'(dma_irq_o), 0);

        // abort during third word's read
        seen_sel = 1'b0;
        reg_write(12'h000, 32'h0000_1000);
        reg_write(12'h004, 32'h0000_2000);
        reg_write(12'h008, 32'h0000_0008);
        push_copy(32'h1000, 32'h2000, 3);
        reg_write(12'h00C, 32'h1);
        n = 0;
        while (bus_exp.size() > 2 && n < 200) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (bus_exp.size() > 2) report_fail("abort_sync_timeout", 32'(bus_exp.size()));
        @(posedge clk);
        reg_write(12'h00C, 32'h4);
        wait_bus_empty();
        repeat (20) @(posedge clk);
        #1;
        reg_read(12'h010, 32'h5);
        reg_read(12'h00C, 32'hA);
        chk("abort_no_irq", 32'(dma_irq_o), 0);

        // config writes and START while busy are ignored
        seen_sel = 1'b0;
        reg_write(12'h000, 32'h0000_0300);
        reg_write(12'h004, 32'h0000_0400);
        reg_write(12'h008, 32'h0000_0002);
        push_copy(32'h300, 32'h400, 2);
        reg_write(12'h00C, 32'h1);
        reg_write(12'h000, 32'hDEAD_0000);
        reg_write(12'h00C, 32'h1);
        reg_read(12'h000, 32'h0000_0300);
        wait_bus_empty();
        repeat (20) @(posedge clk);
        #1;
        reg_read(12'h00C, 32'h2);
        reg_read(12'h010, 32'h0);

        // address wrap
        seen_sel = 1'b0;
        reg_write(12'h000, 32'hFFFF_FFF8);
        reg_write(12'h004, 32'h0000_0500);
        reg_write(12'h008, 32'h0000_0003);
        push_copy(32'hFFFF_FFF8, 32'h500, 3);
        reg_write(12'h00C, 32'h1);
        wait_bus_empty();
        reg_read(12'h00C, 32'h2);

        // reset while writing the first word
        seen_sel = 1'b0;
        reg_write(12'h000, 32'h0000_0600);
        reg_write(12'h004, 32'h0000_0700);
        reg_write(12'h008, 32'h0000_0004);
        bus_exp.push_back('{1'b0, 32'h600, 32'd0});
        reg_write(12'h00C, 32'h3);
        n = 0;
        while (!(m_sel_o && m_we_o) && n < 100) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (!(m_sel_o && m_we_o)) report_fail("wr_wait_timeout", 32'(n));
        @(negedge clk);
        reset_i = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid_m_sel", 32'(m_sel_o), 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mid_m_sel_hold", 32'(m_sel_o), 0);
        chk("rst_mid_m_we", 32'(m_we_o), 0);
        chk("rst_mid_m_addr", m_addr_o, 0);
        chk("rst_mid_exp_drained", 32'(bus_exp.size()), 0);
        bus_exp.delete();
        @(negedge clk);
        reset_i  = 1'b0;
        seen_sel = 1'b0;
        reg_read(12'h000, 32'h0);
        reg_read(12'h004, 32'h0);
        reg_read(12'h008, 32'h0);
        reg_read(12'h00C, 32'h0);
        reg_read(12'h010, 32'h0);
        reg_write(12'h000, 32'h0000_0800);
        reg_write(12'h004, 32'h0000_0900);
        reg_write(12'h008, 32'h0000_0001);
        push_copy(32'h800, 32'h900, 1);
        reg_write(12'h00C, 32'h1);
        wait_bus_empty();
        reg_read(12'h00C, 32'h2);
        reg_read(12'h010, 32'h0);
        chk("final_irq", 32'(dma_irq_o), 0);
        chk("final_rd_queue", 32'(rd_exp.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/dma_copy_device.md
Name: dma_copy_device

Overview:
- Memory-to-memory word copy engine on the SoC bus. It has two ports:
  - a device-side register port, decoded in the 0xE000_0000 device window like timer/led/uart;
  - a second bus initiator port, using the same sel/addr/we/wr_mask/ack protocol the CPU drives.
- The top level arbitrates the initiator port against the CPU.
- Completion raises an interrupt line cleared by an end-of-interrupt pulse.

Parameters:
- LEN_WIDTH, 16, width of the word-count register (max transfer 2^LEN_WIDTH-1 words).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset_i  input  1  synchronous, active-high reset.
- sel_i  input  1  register-port select, held until ack_o.
- wr_en_i  input  1  register-port write (1) / read (0).
- address_in_i  input  12  register byte offset.
- data_in_i  input  32  register write data.
- data_out_o  output  32  register read data.
- ack_o  output  1  register-port acknowledge.
- m_sel_o  output  1  initiator request, held until m_ack_i.
- m_addr_o  output  32  initiator byte address, bits[1:0] always 0.
- m_we_o  output  1  initiator write enable.
- m_data_out_o  output  32  initiator write data.
- m_wr_mask_o  output  4  initiator byte mask, constant 4'hF.
- m_data_in_i  input  32  initiator read data, valid when m_ack_i=1.
- m_ack_i  input  1  initiator acknowledge.
- dma_eoi_i  input  1  end-of-interrupt pulse.
- dma_irq_o  output  1  completion interrupt, level.

Behaviour:
- Register map (bits[4:2] decoded, others ignored):
  - 0x00 SRC, RW: bits[1:0] read 0 and are ignored on write.
  - 0x04 DST, RW: bits[1:0] read 0 and are ignored on write.
  - 0x08 LEN, RW, LEN_WIDTH bits, zero-extended on read.
  - 0x0C CTRL/STATUS:
    - write: bit0 START, bit1 IRQ_EN, bit2 ABORT.
    - read: bit0 BUSY, bit1 DONE, bit2 IRQ_EN, bit3 ABORTED.
  - 0x10 REMAIN, RO: words left.
  - Unmapped offsets read 0; writes to them are ignored.
- Register handshake:
  - ack_o=1 exactly one cycle after the first cycle sel_i is sampled high, for one cycle.
  - ack_o stays low until sel_i has been low at least one cycle.
  - A write takes effect on the ack cycle.
  - data_out_o is valid on the ack cycle and 0 otherwise.
- While BUSY, writes to SRC/DST/LEN are ignored. START while BUSY is ignored. IRQ_EN is always writable.
- START while idle:
  - load working src/dst/REMAIN from SRC/DST/LEN;
  - clear DONE and ABORTED;
  - enter RD, or DONE_ST directly if LEN=0.
- FSM states: IDLE, RD, WR, GAP, DONE_ST.
  - RD: m_sel_o=1, m_we_o=0, m_addr_o=src. On m_ack_i, latch m_data_in_i and go to WR.
  - WR: m_sel_o=1, m_we_o=1, m_addr_o=dst, m_data_out_o=latched word. On m_ack_i: src+=4, dst+=4, REMAIN-=1, go to GAP.
  - GAP: m_sel_o=0 for exactly one cycle, so the responder sees a fresh request. Then go to DONE_ST if REMAIN=0 or abort is pending, else RD.
  - DONE_ST: one cycle. BUSY=0, DONE=1. If IRQ_EN, set irq. Go to IDLE.
- Address arithmetic is 32-bit modulo 2^32; 0xFFFF_FFFC+4 wraps to 0.
- ABORT while BUSY sets an abort-pending flag.
  - The current bus transaction (RD or WR) is never cut short.
  - The engine stops at the next GAP and sets ABORTED and DONE.
  - A read already taken in RD is still written in WR.
  - ABORT while idle has no effect.
- Interrupt:
  - dma_irq_o rises the cycle after DONE_ST with IRQ_EN=1, and stays high until dma_eoi_i=1, then clears the next cycle.
  - If a completion and dma_eoi_i coincide, the completion wins and irq stays set.
  - Clearing IRQ_EN does not drop a pending irq.
- Latency: per word = RD bus latency + WR bus latency + 1 GAP cycle.
- Reset values: all outputs 0; SRC=DST=LEN=REMAIN=0; IRQ_EN=DONE=ABORTED=0; FSM=IDLE.
- Reset mid-transfer: m_sel_o drops the cycle after reset_i is sampled high. No further bus activity. Partial copy is left as-is.

Test Plan:
- SRC=0x100, DST=0x200, LEN=3, START, memory model with 2-cycle ack -> reads 0x100/0x104/0x108, each followed by a write to 0x200/0x204/0x208 with identical data. m_sel_o low exactly one cycle between transactions. STATUS reads 0x2, REMAIN=0.
- LEN=0, START with IRQ_EN=1 -> no m_sel_o activity, DONE=1, dma_irq_o=1 within 2 cycles. dma_eoi_i pulse -> irq 0 next cycle.
- LEN=8, ABORT written during the third word's RD -> third word still written, then stop. REMAIN=5, STATUS=0xA.
- During BUSY, write SRC=0xDEAD_0000 and START -> SRC readback unchanged, transfer continues unaffected.
- SRC=0xFFFF_FFF8, LEN=3 -> read addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- reset_i asserted while m_sel_o=1 in WR -> m_sel_o=0 next cycle, all registers 0, new START afterward runs normally.
